// File: rtl/nand_vector_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : nand_vector_sequencer_if
// Description : Handshake and gate-stimulus bundle for the NAND vector sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface nand_vector_sequencer_if;
  logic       start;
  logic       s_in;
  logic       a_out;
  logic       b_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic       mismatch;
  logic [1:0] fail_idx;

  // master: whoever requests a run and supplies the gate output
  modport master (
    output start, s_in,
    input  a_out, b_out, vec_idx, busy, done, pass, err_count, mismatch, fail_idx
  );

  // slave: the sequencer itself
  modport slave (
    input  start, s_in,
    output a_out, b_out, vec_idx, busy, done, pass, err_count, mismatch, fail_idx
  );
endinterface

`default_nettype wire

// File: rtl/nand_vector_sequencer.sv
//------------------------------------------------------------------------------
// Module      : nand_vector_sequencer
// Description : Drives 00,01,10,11 into a NAND gate, checks each settled output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nand_vector_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  nand_vector_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [2:0]       C_ERR_MAX     = 3'd4;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]       vec_idx_q,   vec_idx_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic [2:0]       err_count_q, err_count_d;
  logic             mismatch_q,  mismatch_d;
  logic [1:0]       fail_idx_q,  fail_idx_d;

  logic             w_expected;
  logic             w_sample_fail;

  // a/b are the two bits of the vector index, so the gate expectation follows it
  assign w_expected    = ~(vec_idx_q[1] & vec_idx_q[0]);
  assign w_sample_fail = (bus.s_in != w_expected);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    mismatch_d  = 1'b0;
    fail_idx_d  = fail_idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          vec_idx_d   = 2'd0;
          err_count_d = 3'd0;
          fail_idx_d  = 2'd0;
          pass_d      = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = C_SETTLE_LOAD;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (w_sample_fail) begin
          mismatch_d = 1'b1;
          if (err_count_q != C_ERR_MAX) begin
            err_count_d = err_count_q + 3'd1;
          end
          if (err_count_q == 3'd0) begin
            fail_idx_d = vec_idx_q;
          end
        end
        if (vec_idx_q == 2'd3) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_count_q == 3'd0) && !w_sample_fail;
        end else begin
          vec_idx_d = vec_idx_q + 2'd1;
          cnt_d     = C_SETTLE_LOAD;
          state_d   = ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vec_idx_q   <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      mismatch_q  <= 1'b0;
      fail_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_idx_q   <= vec_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      mismatch_q  <= mismatch_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign bus.a_out     = vec_idx_q[1];
  assign bus.b_out     = vec_idx_q[0];
  assign bus.vec_idx   = vec_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.fail_idx  = fail_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_nand_vector_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_nand_vector_sequencer
// Description : Random gate-fault runs on SETTLE_CYCLES=1 and =3 sequencers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nand_vector_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start_drv;
  logic s_drv;
  bit   sel;   // 0 -> SETTLE_CYCLES=1 instance, 1 -> SETTLE_CYCLES=3 instance

  always #5 clk = ~clk;

  nand_vector_sequencer_if bus1 ();
  nand_vector_sequencer_if bus3 ();

  assign bus1.start = start_drv & ~sel;
  assign bus3.start = start_drv &  sel;
  assign bus1.s_in  = s_drv;
  assign bus3.s_in  = s_drv;

  nand_vector_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  nand_vector_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  // {a, b, vec_idx, busy, done, pass, err_count, mismatch, fail_idx}
  wire [12:0] obs1 = {bus1.a_out, bus1.b_out, bus1.vec_idx, bus1.busy, bus1.done,
                      bus1.pass, bus1.err_count, bus1.mismatch, bus1.fail_idx};
  wire [12:0] obs3 = {bus3.a_out, bus3.b_out, bus3.vec_idx, bus3.busy, bus3.done,
                      bus3.pass, bus3.err_count, bus3.mismatch, bus3.fail_idx};
  wire [12:0] obs  = sel ? obs3 : obs1;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [12:0] last_exp = '0;

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {ab,vec,busy,done,pass,err,mism,fidx}=%b expected %b",
               tag, $time, got, exp);
    end
  endtask

  // Expected outputs c edges after the start edge, for a gate whose fault
  // pattern is mask (bit v set = vector v returns the wrong value).
  function automatic logic [12:0] model(input logic [3:0] mask, input int c, input int p);
    int         len;
    int         sampled;
    int         v;
    logic [1:0] vb;
    logic [2:0] err;
    logic [1:0] fidx;
    logic       mism;
    len     = 4 * p;
    sampled = c / p;
    v       = (c < len) ? c / p : 3;
    vb      = 2'(v);
    err     = 3'd0;
    fidx    = 2'd0;
    for (int i = 0; i < sampled; i++) begin
      if (mask[i]) begin
        if (err == 3'd0) fidx = 2'(i);
        err = err + 3'd1;
      end
    end
    mism = (c > 0) && (c % p == 0) && mask[c / p - 1];
    return {vb[1], vb[0], vb, (c < len), (c == len), (c == len) && (mask == 4'd0),
            err, mism, fidx};
  endfunction

  // Called at a negedge; returns at a negedge. rst_at>0 asserts reset for edge rst_at.
  task automatic run(input logic [3:0] mask, input bit hold, input int rst_at, input string tag);
    int         p;
    int         len;
    int         v;
    logic [1:0] vb;
    logic [12:0] e;
    p   = sel ? 4 : 2;
    len = 4 * p;
    start_drv = 1'b1;
    s_drv     = 1'($urandom);
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      check_eq(tag, obs, model(mask, c - 1, p));
      v  = (c - 1) / p;
      vb = 2'(v);
      if (c % p == 0) s_drv = ~(vb[1] & vb[0]) ^ mask[v];
      else            s_drv = 1'($urandom);
      start_drv = hold ? 1'b1 : 1'($urandom);
      if (c == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_reset"}, obs, 13'd0);
        reset     = 1'b0;
        start_drv = 1'b0;
        last_exp  = 13'd0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    e = model(mask, len, p);
    check_eq({tag, "_done"}, obs, e);
    last_exp  = e & ~13'b0000000000100;
    start_drv = hold;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq(tag, obs, last_exp);
    end
  endtask

  initial begin
    logic [3:0] m;
    bit         h;
    reset     = 1'b1;
    start_drv = 1'b0;
    s_drv     = 1'b0;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_s1", obs1, 13'd0);
    check_eq("reset_s3", obs3, 13'd0);

    // start and reset together: reset wins, still idle afterwards
    start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_and_start", obs1, 13'd0);
    reset     = 1'b0;
    start_drv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_after_rst_start", obs1, 13'd0);

    run(4'b0000, 1'b0, 0, "nand_ok");
    start_drv = 1'b0;
    idle(3, "done_hold");
    run(4'b1111, 1'b0, 0, "and_gate");
    start_drv = 1'b0;
    idle(2, "and_hold");
    run(4'b1000, 1'b0, 0, "tied_one");
    start_drv = 1'b0;
    idle(2, "tied_hold");

    // SETTLE_CYCLES=3, start held high throughout and into DONE
    sel = 1'b1;
    run(4'b0000, 1'b1, 0, "hold_s3_a");
    run(4'b0101, 1'b1, 0, "hold_s3_restart");
    run(4'b0000, 1'b0, 0, "hold_s3_b");
    start_drv = 1'b0;
    idle(2, "s3_hold");

    // reset on the sample edge of vector 10, then a clean rerun
    sel = 1'b0;
    run(4'b0000, 1'b0, 6, "midrun");
    @(posedge clk);
    @(negedge clk);
    check_eq("post_reset_idle", obs, 13'd0);
    run(4'b0000, 1'b0, 0, "after_reset");
    start_drv = 1'b0;
    idle(1, "after_reset_hold");

    for (int i = 0; i < 14; i++) begin
      sel = 1'($urandom);
      m   = 4'($urandom);
      h   = 1'($urandom);
      run(m, h, 0, sel ? "rand_s3" : "rand_s1");
    end
    start_drv = 1'b0;
    @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
